// File: rtl/control_crono.sv
// rtl/control_crono.sv - BCD HH:MM:SS countdown timer with ring phase and auto-stop
module control_crono #(
    parameter int RING_SEC = 30
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic       ack,
    input  logic [7:0] hh_in,
    input  logic [7:0] mm_in,
    input  logic [7:0] ss_in,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       fin_crono,
    output logic       running,
    output logic       load_err
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        RING  = 2'b11
    } state_t;

    localparam logic [7:0] RING_LAST = 8'(RING_SEC - 1);

    state_t     state;
    logic [7:0] ring_cnt;
    logic [7:0] hh_dec, mm_dec, ss_dec;
    logic       dec_zero, value_zero, load_ok;

    // Nibbles are range-checked first so the packed byte compares act as BCD compares.
    assign load_ok = (hh_in[7:4] <= 4'd9) && (hh_in[3:0] <= 4'd9) &&
                     (mm_in[7:4] <= 4'd9) && (mm_in[3:0] <= 4'd9) &&
                     (ss_in[7:4] <= 4'd9) && (ss_in[3:0] <= 4'd9) &&
                     (ss_in <= 8'h59) && (mm_in <= 8'h59) && (hh_in <= 8'h23);

    assign value_zero = ({hh, mm, ss} == 24'h0);
    assign dec_zero   = ({hh_dec, mm_dec, ss_dec} == 24'h0);

    // One-second BCD decrement with borrow ss -> mm -> hh.
    always_comb begin
        hh_dec = hh;
        mm_dec = mm;
        ss_dec = ss;
        if (ss[3:0] != 4'd0) begin
            ss_dec[3:0] = ss[3:0] - 4'd1;
        end else if (ss[7:4] != 4'd0) begin
            ss_dec = {ss[7:4] - 4'd1, 4'd9};
        end else begin
            ss_dec = 8'h59;
            if (mm[3:0] != 4'd0) begin
                mm_dec[3:0] = mm[3:0] - 4'd1;
            end else if (mm[7:4] != 4'd0) begin
                mm_dec = {mm[7:4] - 4'd1, 4'd9};
            end else begin
                mm_dec = 8'h59;
                if (hh[3:0] != 4'd0) hh_dec[3:0] = hh[3:0] - 4'd1;
                else                 hh_dec      = {hh[7:4] - 4'd1, 4'd9};
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hh        <= 8'h00;
            mm        <= 8'h00;
            ss        <= 8'h00;
            fin_crono <= 1'b0;
            running   <= 1'b0;
            load_err  <= 1'b0;
            ring_cnt  <= 8'h00;
        end else begin
            load_err <= 1'b0;
            // Only the highest-priority active command is considered each cycle.
            if (load) begin
                if (load_ok) begin
                    hh        <= hh_in;
                    mm        <= mm_in;
                    ss        <= ss_in;
                    state     <= IDLE;
                    fin_crono <= 1'b0;
                    running   <= 1'b0;
                    ring_cnt  <= 8'h00;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (ack) begin
                if (state == RING) begin
                    state     <= IDLE;
                    fin_crono <= 1'b0;
                    ring_cnt  <= 8'h00;
                end
            end else if (stop) begin
                if (state == RUN) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end
            end else if (start) begin
                if ((state == IDLE || state == PAUSE) && !value_zero) begin
                    state   <= RUN;
                    running <= 1'b1;
                end
            end else if (tick_1s) begin
                case (state)
                    RUN: begin
                        hh <= hh_dec;
                        mm <= mm_dec;
                        ss <= ss_dec;
                        if (dec_zero) begin
                            state     <= RING;
                            fin_crono <= 1'b1;
                            running   <= 1'b0;
                            ring_cnt  <= 8'h00;
                        end
                    end
                    RING: begin
                        if (ring_cnt == RING_LAST) begin
                            state     <= IDLE;
                            fin_crono <= 1'b0;
                            ring_cnt  <= 8'h00;
                        end else begin
                            ring_cnt <= ring_cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_control_crono.sv
// tb/tb_control_crono.sv - randomized self-checking bench for control_crono against a seconds-based model
module tb_control_crono;
    localparam int RS = 3;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1s = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, ack = 1'b0;
    logic [7:0] hh_in = 8'h00, mm_in = 8'h00, ss_in = 8'h00;
    logic [7:0] hh, mm, ss;
    logic       fin_crono, running, load_err;

    control_crono #(.RING_SEC(RS)) dut (
        .CLK(CLK), .reset(reset), .tick_1s(tick_1s), .load(load), .start(start),
        .stop(stop), .ack(ack), .hh_in(hh_in), .mm_in(mm_in), .ss_in(ss_in),
        .hh(hh), .mm(mm), .ss(ss), .fin_crono(fin_crono), .running(running),
        .load_err(load_err)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    // Model: value kept as total seconds, phase as a small integer (0 idle,1 run,2 pause,3 ring).
    int m_sec = 0, m_phase = 0, m_ring = 0;
    bit m_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    function automatic bit is_valid(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        if (h[7:4] > 9 || h[3:0] > 9 || m[7:4] > 9 || m[3:0] > 9 || s[7:4] > 9 || s[3:0] > 9)
            return 0;
        return bcd2int(h) <= 23 && bcd2int(m) <= 59 && bcd2int(s) <= 59;
    endfunction

    task automatic model_step();
        m_err = 0;
        if (load) begin
            if (is_valid(hh_in, mm_in, ss_in)) begin
                m_sec = bcd2int(hh_in) * 3600 + bcd2int(mm_in) * 60 + bcd2int(ss_in);
                m_phase = 0;
                m_ring = 0;
            end else m_err = 1;
        end else if (ack) begin
            if (m_phase == 3) begin m_phase = 0; m_ring = 0; end
        end else if (stop) begin
            if (m_phase == 1) m_phase = 2;
        end else if (start) begin
            if ((m_phase == 0 || m_phase == 2) && m_sec != 0) m_phase = 1;
        end else if (tick_1s) begin
            if (m_phase == 1) begin
                m_sec--;
                if (m_sec == 0) begin m_phase = 3; m_ring = 0; end
            end else if (m_phase == 3) begin
                m_ring++;
                if (m_ring == RS) begin m_phase = 0; m_ring = 0; end
            end
        end
    endtask

    task automatic check_all();
        chk("hh", 32'(hh), 32'(int2bcd(m_sec / 3600)));
        chk("mm", 32'(mm), 32'(int2bcd((m_sec / 60) % 60)));
        chk("ss", 32'(ss), 32'(int2bcd(m_sec % 60)));
        chk("fin_crono", 32'(fin_crono), 32'(m_phase == 3));
        chk("running", 32'(running), 32'(m_phase == 1));
        chk("load_err", 32'(load_err), 32'(m_err));
    endtask

    task automatic apply(input bit l, input bit a, input bit sp, input bit st, input bit tk,
                         input logic [7:0] h = 8'h00, input logic [7:0] m = 8'h00,
                         input logic [7:0] s = 8'h00);
        load = l; ack = a; stop = sp; start = st; tick_1s = tk;
        hh_in = h; mm_in = m; ss_in = s;
        model_step();
        @(posedge CLK);
        #1;
        check_all();
        load = 0; ack = 0; stop = 0; start = 0; tick_1s = 0;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        apply(1, 0, 0, 0, 0, h, m, s);
    endtask
    task automatic do_tick();  apply(0, 0, 0, 0, 1); endtask
    task automatic do_start(); apply(0, 0, 0, 1, 0); endtask
    task automatic do_stop();  apply(0, 0, 1, 0, 0); endtask
    task automatic do_ack();   apply(0, 1, 0, 0, 0); endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        check_all();
        @(negedge CLK);
        reset = 0;

        // 00:01:05 countdown to ring
        do_load(8'h00, 8'h01, 8'h05);
        do_start();
        for (int i = 0; i < 65; i++) do_tick();
        chk("ring_entry_fin", 32'(fin_crono), 32'd1);
        chk("ring_entry_ss", 32'(ss), 32'h00);

        // auto-stop after RS ticks
        for (int i = 0; i < RS; i++) do_tick();
        chk("auto_stop_fin", 32'(fin_crono), 32'd0);

        // borrow chains
        do_load(8'h01, 8'h00, 8'h00); do_start(); do_tick();
        chk("borrow_mm", 32'(mm), 32'h59);
        do_load(8'h10, 8'h00, 8'h00); do_start(); do_tick();
        chk("borrow_hh", 32'(hh), 32'h09);

        // ack exit
        do_load(8'h00, 8'h00, 8'h01); do_start(); do_tick(); do_tick(); do_ack();
        chk("ack_fin", 32'(fin_crono), 32'd0);

        // pause / resume, including stop+tick together
        do_load(8'h00, 8'h00, 8'h10); do_start();
        for (int i = 0; i < 3; i++) do_tick();
        apply(0, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) do_tick();
        chk("paused_ss", 32'(ss), 32'h07);
        apply(0, 0, 0, 1, 1);
        for (int i = 0; i < 7; i++) do_tick();
        chk("resume_ring", 32'(fin_crono), 32'd1);

        // invalid loads, then start at zero
        do_load(8'h00, 8'h00, 8'h60);
        do_load(8'h24, 8'h00, 8'h00);
        do_load(8'h00, 8'h0A, 8'h00);
        apply(0, 1, 0, 0, 1);
        do_start();
        chk("start_zero", 32'(running), 32'd0);

        // async reset mid-ring
        do_load(8'h00, 8'h00, 8'h02); do_start(); do_tick(); do_tick();
        @(posedge CLK);
        #2;
        reset = 1;
        #1;
        m_sec = 0; m_phase = 0; m_ring = 0; m_err = 0;
        chk("async_fin", 32'(fin_crono), 32'd0);
        check_all();
        @(negedge CLK);
        reset = 0;

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [7:0] h, m, s;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                if ($urandom_range(0, 2) == 0) begin
                    h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
                end else begin
                    h = 8'h00; m = int2bcd(int'($urandom_range(0, 1)));
                    s = int2bcd(int'($urandom_range(0, 59)));
                end
                apply(1, $urandom_range(0, 1) == 1, 0, 0, $urandom_range(0, 1) == 1, h, m, s);
            end else if (r < 8)  apply(0, 1, 0, 0, $urandom_range(0, 1) == 1);
            else if (r < 12)     apply(0, 0, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            else if (r < 20)     apply(0, 0, 0, 1, $urandom_range(0, 1) == 1);
            else if (r < 75)     do_tick();
            else                 apply(0, 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
